lut_prog_engine: RTL and testbench

//  Parametrised, runtime-reprogrammable lookup table with a registered read pipeline.

---
 rtl/lut_prog_engine.sv | 108 ++++++++++
 tb/tb_lut_prog_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lut_prog_engine.sv
// Runtime-reprogrammable lookup table with a registered 1-cycle read, single-entry
// writes and a sequential bulk-load stream. Optional per-entry parity: LUT_PARITY_EN.
module lut_prog_engine #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 1,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] INIT = 8'hB9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dvalid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              par_err
);

    // state | meaning
    // IDLE  | reads and single-entry writes accepted
    // LOAD  | bulk reload in progress, entries filled 0..DEPTH-1 from the stream
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_acc;
    logic              wr_acc;
    logic              ld_beat;
    logic              ld_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        ld_beat   = 1'b0;
        ld_last   = 1'b0;
        unique case (state)
            IDLE: begin
                rd_acc = rd_valid;
                wr_acc = wr_en;
                if (ld_start) state_nxt = LOAD;
            end
            LOAD: begin
                ld_beat = ld_valid;
                ld_last = ld_valid && (cnt == ADDR_W'(DEPTH-1));
                if (ld_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_ready = (state == IDLE);
    assign ld_busy  = (state == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT[i*DATA_W +: DATA_W];
            cnt       <= '0;
            rd_data   <= '0;
            rd_dvalid <= 1'b0;
            ld_done   <= 1'b0;
        end else begin
            rd_dvalid <= rd_acc;
            ld_done   <= ld_last;
            // nonblocking update gives read-before-write on an address collision
            if (rd_acc) rd_data <= mem[rd_addr];
            if (wr_acc) mem[wr_addr] <= wr_data;
            if (state == IDLE && ld_start) cnt <= '0;
            if (ld_beat) begin
                mem[cnt] <= ld_data;
                cnt      <= cnt + ADDR_W'(1);
            end
        end
    end

`ifdef LUT_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= ^INIT[i*DATA_W +: DATA_W];
            par_err <= 1'b0;
        end else begin
            par_err <= rd_acc && ((^mem[rd_addr]) != par_mem[rd_addr]);
            if (wr_acc)  par_mem[wr_addr] <= ^wr_data;
            if (ld_beat) par_mem[cnt]     <= ^ld_data;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_prog_engine.sv
// Directed self-checking bench for lut_prog_engine at default parameters (INIT=8'hB9).
// Define LUT_PARITY_EN for both files to include the parity-corruption step.
module tb_lut_prog_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] rd_addr;
    logic [0:0] rd_data;
    logic       rd_dvalid;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [0:0] wr_data;
    logic       ld_start;
    logic       ld_valid;
    logic [0:0] ld_data;
    logic       ld_busy;
    logic       ld_done;
    logic       par_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] init_v = 8'hB9;

    always #5 clk = ~clk;

    lut_prog_engine dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_dvalid(rd_dvalid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_busy(ld_busy), .ld_done(ld_done), .par_err(par_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_one(input string tag, input logic [2:0] a, input logic exp);
        rd_valid = 1'b1;
        rd_addr  = a;
        tick();
        rd_valid = 1'b0;
        check({tag, "_dvalid"}, 32'(rd_dvalid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        check({tag, "_par"}, 32'(par_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rd_valid = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;

        // reset state
        tick(); tick();
        check("rst_dvalid", 32'(rd_dvalid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_par", 32'(par_err), 32'd0);
        check("rst_ready", 32'(rd_ready), 32'd1);
        rst = 1'b0;
        tick();
        check("idle_dvalid", 32'(rd_dvalid), 32'd0);

        // 1: back-to-back reads of INIT contents
        rd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            check("t1_dvalid", 32'(rd_dvalid), 32'd1);
            check("t1_data", 32'(rd_data), 32'(init_v[i]));
        end
        rd_valid = 1'b0;
        tick();
        check("t1_gap_dvalid", 32'(rd_dvalid), 32'd0);
        check("t1_hold_data", 32'(rd_data), 32'd1);

        // 2: same-cycle write and read of addr 2
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 1'b1;
        rd_valid = 1'b1; rd_addr = 3'd2;
        tick();
        wr_en = 1'b0; rd_valid = 1'b0;
        check("t2_rbw_data", 32'(rd_data), 32'd0);
        check("t2_rbw_dvalid", 32'(rd_dvalid), 32'd1);
        read_one("t2_new", 3'd2, 1'b1);

        // 3 and 5: load 0,1,0,1,... with gaps carrying writes, reads and a stray ld_start
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("t3_busy_start", 32'(ld_busy), 32'd1);
        check("t3_ready_start", 32'(rd_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_data  = 1'(i & 1);
            tick();
            ld_valid = 1'b0;
            if (i < 7) begin
                check("t3_busy", 32'(ld_busy), 32'd1);
                check("t3_done_early", 32'(ld_done), 32'd0);
                wr_en = 1'b1; wr_addr = 3'(i); wr_data = 1'(~i & 1);
                rd_valid = 1'b1; rd_addr = 3'(i);
                ld_start = (i == 3);
                tick();
                wr_en = 1'b0; rd_valid = 1'b0; ld_start = 1'b0;
                check("t5_no_dvalid", 32'(rd_dvalid), 32'd0);
                check("t5_ready_low", 32'(rd_ready), 32'd0);
            end
        end
        check("t3_done", 32'(ld_done), 32'd1);
        check("t3_busy_end", 32'(ld_busy), 32'd0);
        tick();
        check("t3_done_pulse", 32'(ld_done), 32'd0);
        for (int i = 0; i < 8; i++) read_one("t3_rd", 3'(i), 1'(i & 1));

        // 4: reset in the middle of a load (load starts alongside a write)
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 1'b0; ld_start = 1'b1;
        tick();
        wr_en = 1'b0; ld_start = 1'b0;
        check("t4_busy", 32'(ld_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 1'(~init_v[i]);
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy_rst", 32'(ld_busy), 32'd0);
        check("t4_ready_rst", 32'(rd_ready), 32'd1);
        check("t4_done_rst", 32'(ld_done), 32'd0);
        read_one("t4_a0", 3'd0, 1'b1);
        read_one("t4_a1", 3'd1, 1'b0);
        read_one("t4_a3", 3'd3, 1'b1);
        read_one("t4_a5", 3'd5, 1'b1);
        read_one("t4_a7", 3'd7, 1'b1);

`ifdef LUT_PARITY_EN
        // 6: corrupt stored data at addr 3, parity must flag it
        dut.mem[3] = ~dut.mem[3];
        rd_valid = 1'b1; rd_addr = 3'd3;
        tick();
        rd_valid = 1'b0;
        check("t6_dvalid", 32'(rd_dvalid), 32'd1);
        check("t6_par_err", 32'(par_err), 32'd1);
        read_one("t6_clean", 3'd4, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
